// File: rtl/sobel_pkg.sv
// Shared constants and state encodings for the Sobel result reader.
// The optional sync header (SOBEL_READER_HEADER_EN) uses HDR_BYTE0/HDR_BYTE1.
package sobel_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int PIX_W  = 8;

  localparam logic [PIX_W-1:0] HDR_BYTE0 = 8'hA5;
  localparam logic [PIX_W-1:0] HDR_BYTE1 = 8'h5A;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_HEADER,
    RD_HDR_WAIT,
    RD_FETCH,
    RD_CAPTURE,
    RD_SEND,
    RD_NEXT,
    RD_DONE
  } reader_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START_BIT,
    TX_DATA_BITS,
    TX_STOP_BIT
  } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter: start bit, 8 data bits LSB first, stop bit.
// tx_done is a combinational pulse in the final cycle of the stop bit.
module uart_tx_byte
  import sobel_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        shreg, shreg_n;
  logic              tx_n;
  logic              bit_end;

  assign bit_end = (baud == BAUD_LAST);
  assign tx_busy = (state != TX_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

  // tx is registered: the level for each bit is decided on the edge that enters it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n   = state;
    baud_n    = baud + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx;
    tx_done   = 1'b0;
    case (state)
      TX_IDLE: begin
        baud_n = '0;
        if (tx_start) begin
          state_n = TX_START_BIT;
          shreg_n = tx_data;
          tx_n    = 1'b0;
        end
      end
      TX_START_BIT: begin
        if (bit_end) begin
          state_n   = TX_DATA_BITS;
          baud_n    = '0;
          bit_idx_n = '0;
          tx_n      = shreg[0];
        end
      end
      TX_DATA_BITS: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = TX_STOP_BIT;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end
      end
      TX_STOP_BIT: begin
        if (bit_end) begin
          state_n = TX_IDLE;
          baud_n  = '0;
          tx_done = 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/sobel_result_uart_reader.sv
// Streams the binarized Sobel frame from the result BRAM over UART, one byte per pixel.
// Define SOBEL_READER_HEADER_EN to prefix each frame with the sync bytes 0xA5 0x5A.
module sobel_result_uart_reader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMG_W        = sobel_pkg::IMG_W,
  parameter int IMG_H        = sobel_pkg::IMG_H,
  parameter int ADDR_W       = sobel_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_enable,
  input  logic [7:0]        read_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              frame_done
);

  import sobel_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

  reader_state_t     state, state_n;
  logic              start_prev;
  logic              start_rise;
  logic [ADDR_W-1:0] pix_cnt, pix_cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;
`ifdef SOBEL_READER_HEADER_EN
  logic              hdr_cnt, hdr_cnt_n;
`endif

  assign start_rise  = start & ~start_prev;
  assign read_enable = (state == RD_FETCH);
  assign busy        = (state != RD_IDLE);
  assign frame_done  = (state == RD_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RD_IDLE;
      start_prev   <= 1'b0;
      pix_cnt      <= '0;
      read_address <= '0;
`ifdef SOBEL_READER_HEADER_EN
      hdr_cnt      <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      start_prev   <= start;
      pix_cnt      <= pix_cnt_n;
      read_address <= addr_n;
`ifdef SOBEL_READER_HEADER_EN
      hdr_cnt      <= hdr_cnt_n;
`endif
    end
  end

  // read_address is loaded only on the edge that enters FETCH, so it holds between fetches.
  always_comb begin
    state_n   = state;
    pix_cnt_n = pix_cnt;
    addr_n    = read_address;
    tx_start  = 1'b0;
    tx_data   = read_data;
`ifdef SOBEL_READER_HEADER_EN
    hdr_cnt_n = hdr_cnt;
`endif
    case (state)
      RD_IDLE: begin
        if (start_rise) begin
`ifdef SOBEL_READER_HEADER_EN
          state_n   = RD_HEADER;
          hdr_cnt_n = 1'b0;
`else
          state_n = RD_FETCH;
          addr_n  = pix_cnt;
`endif
        end
      end
`ifdef SOBEL_READER_HEADER_EN
      RD_HEADER: begin
        tx_data = hdr_cnt ? HDR_BYTE1 : HDR_BYTE0;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = RD_HDR_WAIT;
        end
      end
      RD_HDR_WAIT: begin
        if (tx_done) begin
          if (hdr_cnt) begin
            hdr_cnt_n = 1'b0;
            addr_n    = pix_cnt;
            state_n   = RD_FETCH;
          end else begin
            hdr_cnt_n = 1'b1;
            state_n   = RD_HEADER;
          end
        end
      end
`endif
      RD_FETCH: state_n = RD_CAPTURE;
      RD_CAPTURE: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = RD_SEND;
        end
      end
      RD_SEND: begin
        if (tx_done) state_n = (pix_cnt == LAST_PIX) ? RD_DONE : RD_NEXT;
      end
      RD_NEXT: begin
        pix_cnt_n = pix_cnt + 1'b1;
        addr_n    = pix_cnt + 1'b1;
        state_n   = RD_FETCH;
      end
      RD_DONE: begin
        pix_cnt_n = '0;
        state_n   = RD_IDLE;
      end
      default: state_n = RD_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (uart_tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

endmodule

// File: tb/tb_sobel_result_uart_reader.sv
// Scoreboard bench for sobel_result_uart_reader on a reduced 16x8 frame with CLKS_PER_BIT=4.
// Stimulus pushes expected bytes/addresses; independent monitors decode the UART line and reads.
`timescale 1ns/1ps
module tb_sobel_result_uart_reader;

  localparam int CPB     = 4;
  localparam int IMG_W   = 16;
  localparam int IMG_H   = 8;
  localparam int ADDR_W  = 7;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int PIX_CYC = 10 * CPB + 3;
`ifdef SOBEL_READER_HEADER_EN
  localparam int HDR_BYTES = 2;
  localparam int START_LAT = 2;
`else
  localparam int HDR_BYTES = 0;
  localparam int START_LAT = 3;
`endif
  localparam int FRAME_CYC = (NPIX + HDR_BYTES) * PIX_CYC + 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] read_address;
  logic              read_enable;
  logic [7:0]        read_data;
  logic              uart_tx;
  logic              busy;
  logic              frame_done;

  logic [7:0]        mem [NPIX];
  logic [7:0]        exp_bytes [$];
  logic [ADDR_W-1:0] exp_addr [$];
  int                errors = 0;
  int                checks = 0;
  int                done_cnt = 0;
  int                re_cnt = 0;
  logic [7:0]        last_byte = 8'h00;
  logic [7:0]        prev_byte = 8'h00;

  always #5 clk = ~clk;

  sobel_result_uart_reader #(
    .CLKS_PER_BIT(CPB),
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .read_address(read_address),
    .read_enable (read_enable),
    .read_data   (read_data),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // Result BRAM model: data valid the cycle after the read strobe.
  always @(posedge clk) if (read_enable) read_data <= mem[read_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART line decoder: every cycle of each bit must hold the same level.
  initial begin : uart_mon
    int         k;
    logic [9:0] bits;
    logic       glitch;
    logic       active;
    active = 1'b0; k = 0; bits = '0; glitch = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) active = 1'b0;
      else begin
        if (!active && uart_tx === 1'b0) begin
          active = 1'b1; k = 0; glitch = 1'b0;
        end
        if (active) begin
          if (k % CPB == 0) bits[k / CPB] = uart_tx;
          else if (uart_tx !== bits[k / CPB]) glitch = 1'b1;
          k++;
          if (k == 10 * CPB) begin
            active = 1'b0;
            check("uart_framing", {29'd0, glitch, bits[0], bits[9]}, 32'd1);
            check("uart_byte_expected", exp_bytes.size() > 0, 1);
            if (exp_bytes.size() > 0) check("uart_byte", bits[8:1], exp_bytes.pop_front());
            prev_byte = last_byte;
            last_byte = bits[8:1];
          end
        end
      end
    end
  end

  // BRAM read monitor: strobes are single cycles and addresses arrive in scoreboard order.
  initial begin : rd_mon
    logic prev_re;
    prev_re = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_re = 1'b0;
        re_cnt  = 0;
      end else begin
        if (read_enable) begin
          check("re_back_to_back", prev_re, 0);
          re_cnt++;
          check("read_expected", exp_addr.size() > 0, 1);
          if (exp_addr.size() > 0) check("read_address", read_address, exp_addr.pop_front());
        end
        prev_re = read_enable;
      end
    end
  end

  // Frame-end monitor: everything delivered at frame_done, busy drops one cycle later.
  initial begin : done_mon
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_prev) begin
        check("busy_after_done", busy, 0);
        check("done_one_cycle", frame_done, 0);
      end
      done_prev = 1'b0;
      if (!rst && frame_done) begin
        done_cnt++;
        done_prev = 1'b1;
        check("busy_at_done", busy, 1);
        check("done_bytes_left", exp_bytes.size(), 0);
        check("done_reads_left", exp_addr.size(), 0);
        check("done_read_count", re_cnt, NPIX);
        re_cnt = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference behaviour of one accepted start edge: optional header, then pixels 0..NPIX-1.
  task automatic start_frame();
`ifdef SOBEL_READER_HEADER_EN
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h5A);
`endif
    for (int a = 0; a < NPIX; a++) begin
      exp_bytes.push_back(mem[a]);
      exp_addr.push_back(ADDR_W'(a));
    end
    start = 1'b1;
    repeat (START_LAT - 1) @(negedge clk);
    check("tx_high_before_start_bit", uart_tx, 1);
    @(negedge clk);
    check("start_bit_latency", uart_tx, 0);
  endtask

  task automatic wait_frame(input int target);
    int n = 0;
    while (done_cnt < target && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    check("frame_completed", done_cnt >= target, 1);
  endtask

  task automatic fill_random();
    for (int a = 0; a < NPIX; a++) mem[a] = 8'($urandom);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int a = 0; a < NPIX; a++) mem[a] = 8'(a);
    wait_cycles(3);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_read_enable", read_enable, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_read_address", read_address, 0);
    rst = 1'b0;
    wait_cycles(2 + $urandom_range(0, 5));

    // Frame 1: ramp pattern, start held high for two frame times.
    start_frame();
    wait_frame(1);
    wait_cycles(FRAME_CYC);
    check("held_start_frames", done_cnt, 1);
    check("held_start_idle", busy, 0);
    start = 1'b0;
    wait_cycles(3);

    // Frame 2: random pixels, 0x96 first, 0xFF/0x00 last, extra start pulse mid-frame.
    fill_random();
    mem[0]        = 8'h96;
    mem[NPIX - 2] = 8'hFF;
    mem[NPIX - 1] = 8'h00;
    start_frame();
    wait_cycles($urandom_range(50, FRAME_CYC / 2));
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame(2);
    check("second_last_byte", prev_byte, 8'hFF);
    check("last_byte", last_byte, 8'h00);
    wait_cycles(3 * PIX_CYC);
    check("mid_pulse_frames", done_cnt, 2);
    check("mid_pulse_idle", busy, 0);

    // Frame 3: reset during the data bits of pixel 5.
    fill_random();
    start_frame();
    wait_cycles((HDR_BYTES + 5) * PIX_CYC + CPB + 3 * CPB);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("mid_rst_uart_tx", uart_tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_read_enable", read_enable, 0);
    exp_bytes.delete();
    exp_addr.delete();
    rst = 1'b0;
    wait_cycles(5 + $urandom_range(0, 10));
    check("idle_after_rst", busy, 0);

    // Frame 4: restart from address 0 after the reset.
    fill_random();
    start_frame();
    wait_frame(3);
    start = 1'b0;
    wait_cycles(20);
    check("frame_count", done_cnt, 3);
    check("final_idle_tx", uart_tx, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_result_uart_reader.md
Name: sobel_result_uart_reader

Overview:
- Reads the finished 128x128 binarized Sobel image out of the result BRAM, the same memory the Sobel control unit writes.
- Streams it row-major to a host over UART as 8N1 bytes, one byte per pixel.
- Started by the control unit's image-generation-complete signal; busy for one full frame; then idle until the next rising edge of start.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); minimum legal value 2.
- IMG_W, 128, pixels per row.
- IMG_H, 128, rows per frame.
- ADDR_W, 14, BRAM address width; must equal log2(IMG_W*IMG_H).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level from sobel_control_unit image_generation_complete; only its rising edge is used internally.
- read_address  out  ADDR_W  to result BRAM port B; equals {y[6:0], x[6:0]}.
- read_enable  out  1  to result BRAM; high for exactly one cycle per pixel fetch.
- read_data  in  8  from result BRAM; valid in the cycle after the cycle in which read_enable is high.
- uart_tx  out  1  serial output; idles high.
- busy  out  1  high from the accepted start edge until the DONE state is left.
- frame_done  out  1  one-cycle pulse after the stop bit of the last pixel.

Behaviour:
- Reset values:
  - read_address=0, read_enable=0, uart_tx=1, busy=0, frame_done=0.
  - Pixel counter=0, baud counter=0, bit index=0, start_prev=0, state=IDLE.
- Reset mid-frame: at the reset edge everything returns to these values, uart_tx is forced high immediately, and the partial byte is abandoned.
- Start detection:
  - start_rise = start & ~start_prev; start_prev is registered every cycle.
  - A start held high therefore triggers exactly one frame.
  - If start is already high when reset releases, the first cycle detects an edge and a frame is sent.
  - A start edge seen while busy=1 is ignored and not queued.
- States: IDLE, FETCH, CAPTURE, START_BIT, DATA_BITS, STOP_BIT, NEXT, DONE.
  - IDLE: on start_rise go to FETCH and set busy=1.
  - FETCH: read_enable=1 and read_address=pixel counter for this one cycle; go to CAPTURE.
  - CAPTURE: latch read_data into the 8-bit shift register; go to START_BIT.
  - START_BIT: uart_tx=0 for CLKS_PER_BIT cycles; go to DATA_BITS.
  - DATA_BITS: LSB first, 8 bits, each held CLKS_PER_BIT cycles; go to STOP_BIT.
  - STOP_BIT: uart_tx=1 for CLKS_PER_BIT cycles. If the pixel counter equals IMG_W*IMG_H-1, go to DONE; otherwise go to NEXT.
  - NEXT: increment the pixel counter; go to FETCH.
  - DONE: frame_done=1 for one cycle; pixel counter wraps to 0; busy=0 on the next cycle; go to IDLE.
- Timing:
  - Per-pixel period is 10*CLKS_PER_BIT+3 cycles (FETCH, CAPTURE and NEXT add one cycle each).
  - The first start-bit falling edge on uart_tx occurs 3 cycles after the start_rise cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - Width is $clog2(CLKS_PER_BIT).
- Address and counter rules:
  - read_address changes only in FETCH and is held between fetches.
  - The pixel counter is unsigned ADDR_W bits and never exceeds IMG_W*IMG_H-1.
- read_data is not sampled outside CAPTURE. Data is sent as stored, with no thresholding or inversion.

Optional Feature:
- Macro: SOBEL_READER_HEADER_EN.
- When defined:
  - Before pixel 0, two sync bytes are sent: 0xA5 then 0x5A.
  - They use the same 8N1 framing and are sourced from constants, with no BRAM read.
  - A HEADER state precedes FETCH, and a header counter selects the byte.
  - The total frame is 16386 bytes.
- When undefined: exactly 16384 bytes are sent, and the first byte on the line is pixel 0.

Decomposition:
- Shared package sobel_pkg:
  - Constants IMG_W, IMG_H, ADDR_W, PIX_W=8.
  - HDR_BYTE0=8'hA5, HDR_BYTE1=8'h5A.
  - Reader state enum typedef.
- One sub-module, uart_tx_byte:
  - Parameter CLKS_PER_BIT.
  - Inputs: clk, rst, tx_start, tx_data[7:0]. Outputs: tx, tx_busy, tx_done.
  - Owns START_BIT, DATA_BITS and STOP_BIT.
  - The top FSM keeps IDLE, FETCH, CAPTURE, NEXT, DONE (and HEADER) and waits on tx_done.

Test Plan:
- Single-frame stream:
  - Stimulus: CLKS_PER_BIT=4; BRAM model with 1-cycle latency preloaded with mem[a]=a[7:0]; start raised and held.
  - Required: UART monitor decodes exactly 16384 bytes 0x00,0x01,...,0xFF repeating; one frame_done pulse; busy falls the cycle after frame_done.
  - Required: with the macro defined, 0xA5 0x5A precede those bytes.
- Framing and latency:
  - Stimulus: mem[0]=8'h96.
  - Required: uart_tx falls 3 cycles after start_rise; bits observed low, then 0,1,1,0,1,0,0,1 (LSB first), then high, each lasting 4 cycles.
- Read handshake:
  - Stimulus: one full frame.
  - Required: read_enable is high exactly 16384 cycles in total, never on consecutive cycles; each read_address seen once, in order 0..16383; the last address is 14'h3FFF.
- Start edge rules:
  - Stimulus: start pulsed again mid-frame; start held high for 2 frame times; start toggled 0->1 after DONE.
  - Required: no extra bytes from the mid-frame pulse or the held-high start; a new frame begins from address 0 after the 0->1 toggle.
- Reset mid-frame:
  - Stimulus: rst asserted for 1 cycle during DATA_BITS of pixel 5.
  - Required: on the next cycle uart_tx=1, busy=0, read_enable=0; a subsequent start_rise restarts at address 0.
- Boundary pixel values:
  - Stimulus: mem[16383]=8'h00 and mem[16382]=8'hFF.
  - Required: the last two decoded bytes are 0xFF then 0x00, with a valid stop bit on each.
